subchain_accum: RTL and testbench
=================================

SUBCHAIN_ACCUM -- requirements
Module: subchain_accum

Interface
REQ-001 Parameter WD, default 4: width of the data word (matches the upstream bit-chain stage output width).
REQ-002 Parameter FRAME_LEN, default 8: words per frame; legal range 2..256.
REQ-003 CLK  input  1: single clock; all state updates on the rising edge.
REQ-004 RST_X  input  1: reset, synchronous, active-low.
REQ-005 in_valid  input  1: upstream word valid.
REQ-006 in_ready  output  1: block accepts a word this cycle.
REQ-007 in_data  input  WD: upstream word (the bit-chain stage's output).
REQ-008 clr  input  1: synchronous abort of the frame in progress.
REQ-009 out_valid  output  1: frame checksum valid.
REQ-010 out_ready  input  1: downstream accepts the checksum.
REQ-011 out_data  output  WD: XOR checksum of the frame.
REQ-012 frame_cnt  output  8: count of delivered frames, wrapping.

Function
REQ-013 The block SHALL be a two-state FSM: ACCUM and HOLD.
REQ-014 in_ready SHALL be 1 in ACCUM and 0 in HOLD, decoded from registered state only, with no combinational path from any input.
REQ-015 A word is accepted when in_valid && in_ready on a rising edge.
REQ-016 In ACCUM, each accepted word SHALL update acc <= acc ^ in_data and word counter cnt <= cnt + 1.
REQ-017 An accepted word with cnt == FRAME_LEN-1 closes the frame.
  - out_data <= acc ^ in_data; out_valid <= 1
  - acc <= 0; cnt <= 0
  - state <= HOLD
REQ-018 Latency: out_valid SHALL assert in the cycle after the last word of the frame is accepted.
REQ-019 In HOLD, out_data and out_valid SHALL remain stable until out_ready is sampled high.
REQ-020 In HOLD with out_ready=1: out_valid <= 0, frame_cnt <= frame_cnt + 1 (mod 256), state <= ACCUM.
  - No input word is accepted in that same cycle (in_ready is 0 in HOLD).
REQ-021 out_ready while in ACCUM SHALL have no effect.
REQ-022 clr=1 in ACCUM SHALL set acc <= 0 and cnt <= 0 and discard any word presented that cycle; in_ready stays 1.
REQ-023 clr=1 in HOLD SHALL be ignored: the pending checksum is not dropped.
REQ-024 in_valid=0 in ACCUM SHALL leave acc and cnt unchanged; gaps between words are legal.
REQ-025 cnt SHALL be $clog2(FRAME_LEN) bits wide; it never exceeds FRAME_LEN-1.
REQ-026 frame_cnt SHALL wrap from 255 to 0 with no flag.

Reset
REQ-027 On RST_X=0 at a rising edge:
  - state <= ACCUM; acc <= 0; cnt <= 0
  - out_valid <= 0; out_data <= 0; frame_cnt <= 0
REQ-028 Reset SHALL take precedence over clr and over all handshakes, including mid-frame and during HOLD; a pending checksum is discarded.
REQ-029 While RST_X=0, in_ready SHALL read 1 (ACCUM), but no word is accepted.

Verification (WD=4, FRAME_LEN=4)
REQ-030 Words 1,2,4,8 back-to-back with out_ready=1 -> out_valid=1 with out_data=F one cycle after word 8; frame_cnt=1 the following cycle.
REQ-031 Words 3,3,5,5 with in_valid gaps of 2 cycles -> out_data=0, out_valid=1 once.
REQ-032 Frame 1,1,1,1 with out_ready=0 for 3 cycles -> out_data=0 held stable, in_ready=0 for 4 cycles, and in_valid words offered meanwhile are not consumed.
REQ-033 Words 7,7 then clr=1, then A,0,0,0 -> out_data=A.
  - clr asserted together with a presented word 5 -> that word is ignored.
REQ-034 RST_X=0 after 2 words, and again during HOLD -> all outputs 0 next cycle; next frame 1,2,4,8 -> F.
REQ-035 256 frames delivered -> frame_cnt wraps to 0 after the 256th out_ready handshake.

Source files
------------

// File: rtl/subchain_accum.sv
// Frame XOR checksum accumulator: folds FRAME_LEN upstream words into one checksum
// and holds it in HOLD until the downstream handshake, counting delivered frames.
module subchain_accum #(
  parameter int WD        = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] in_data,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] out_data,
  output logic [7:0]    frame_cnt
);

  localparam int               CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WD-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WD-1:0]    out_data_q, out_data_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  // in_ready depends on the state register alone, so upstream sees no input-to-output path.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ACCUM: begin
        if (clr) begin
          // Abort wins over a word presented in the same cycle.
          acc_d = '0;
          cnt_d = '0;
        end else if (in_valid) begin
          if (cnt_q == LAST_CNT) begin
            out_data_d  = acc_q ^ in_data;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d = acc_q ^ in_data;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // clr is deliberately ignored here so a finished checksum is never lost.
        if (out_ready) begin
          out_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state uses non-blocking assignments so all registers update together from pre-edge values.
    if (!RST_X) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_subchain_accum.sv
// Scoreboard bench for subchain_accum (WD=4, FRAME_LEN=4): expected checksums are
// queued as words are driven and popped when the DUT presents out_valid.
module tb_subchain_accum;

  localparam int WD = 4;
  localparam int FL = 4;

  logic          CLK = 1'b0;
  logic          RST_X;
  logic          in_valid;
  logic          in_ready;
  logic [WD-1:0] in_data;
  logic          clr;
  logic          out_valid;
  logic          out_ready;
  logic [WD-1:0] out_data;
  logic [7:0]    frame_cnt;

  subchain_accum #(.WD(WD), .FRAME_LEN(FL)) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_cnt (frame_cnt)
  );

  always #5 CLK = ~CLK;

  int            checks   = 0;
  int            failures = 0;
  logic [WD-1:0] exp_q[$];
  logic [WD-1:0] m_acc;
  int            m_cnt;
  logic [7:0]    m_frames;

  // Advance one cycle; all sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one word for one cycle (DUT assumed in ACCUM) and update the model.
  task automatic send(input logic [WD-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    m_acc    = m_acc ^ d;
    m_cnt++;
    if (m_cnt == FL) begin
      exp_q.push_back(m_acc);
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [WD-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic model_reset();
    m_acc    = '0;
    m_cnt    = 0;
    m_frames = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    RST_X     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h5;
    clr       = 1'b0;
    out_ready = 1'b0;
    model_reset();
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h cnt=%0d want 0/0/0", out_valid, out_data, frame_cnt);
    end
    in_valid = 1'b0;
    RST_X    = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WD-1:0] e;
    out_ready = 1'b1;
    send(4'h1); send(4'h2); send(4'h4);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_early_valid: got %b want 0", out_valid);
    end
    send(4'h8);
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      failures++; $display("FAIL b2b_checksum: got valid=%b data=%h want 1/%h", out_valid, out_data, e);
    end
    checks++;
    if (e !== 4'hF) begin
      failures++; $display("FAIL b2b_model: got %h want F", e);
    end
    tick();
    m_frames++;
    checks++;
    if (out_valid !== 1'b0 || frame_cnt !== m_frames || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_handshake: got valid=%b cnt=%0d rdy=%b want 0/%0d/1", out_valid, frame_cnt, in_ready, m_frames);
    end
  endtask

  task automatic test_gaps();
    logic [WD-1:0] e;
    int            highs;
    out_ready = 1'b0;
    send(4'h3); idle(2);
    send(4'h3); idle(2);
    send(4'h5); idle(2);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL gaps_early_valid: got %b want 0", out_valid);
    end
    send(4'h5);
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      failures++; $display("FAIL gaps_checksum: got valid=%b data=%h want 1/%h", out_valid, out_data, e);
    end
    out_ready = 1'b1;
    tick();
    m_frames++;
    highs = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid === 1'b1) highs++;
      tick();
    end
    checks++;
    if (highs !== 0 || frame_cnt !== m_frames) begin
      failures++; $display("FAIL gaps_single_valid: got extra=%0d cnt=%0d want 0/%0d", highs, frame_cnt, m_frames);
    end
  endtask

  task automatic test_hold();
    logic [WD-1:0] e;
    int            bad;
    out_ready = 1'b0;
    send(4'h1); send(4'h1); send(4'h1); send(4'h1);
    e = pop_exp();
    // Offer a word and a clr while holding; neither may disturb the checksum.
    in_valid = 1'b1;
    in_data  = 4'h7;
    bad      = 0;
    for (int i = 0; i < 4; i++) begin
      clr = (i == 1);
      if (i == 3) out_ready = 1'b1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== e) bad++;
      tick();
    end
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    m_frames++;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL hold_stable: got %0d unstable cycles want 0 (expected data %h)", bad, e);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== m_frames) begin
      failures++;
      $display("FAIL hold_release: got valid=%b rdy=%b cnt=%0d want 0/1/%0d", out_valid, in_ready, frame_cnt, m_frames);
    end
    out_ready = 1'b1;
    send(4'h1); send(4'h2); send(4'h4); send(4'h8);
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      failures++; $display("FAIL hold_no_consume: got valid=%b data=%h want 1/%h", out_valid, out_data, e);
    end
    tick();
    m_frames++;
  endtask

  task automatic test_clr();
    logic [WD-1:0] e;
    out_ready = 1'b1;
    send(4'h7); send(4'h7);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h5;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL clr_in_ready: got %b want 1", in_ready);
    end
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    m_acc    = '0;
    m_cnt    = 0;
    send(4'hA); send(4'h0); send(4'h0); send(4'h0);
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      failures++; $display("FAIL clr_checksum: got valid=%b data=%h want 1/%h", out_valid, out_data, e);
    end
    tick();
    m_frames++;
    checks++;
    if (frame_cnt !== m_frames) begin
      failures++; $display("FAIL clr_frame_cnt: got %0d want %0d", frame_cnt, m_frames);
    end
  endtask

  task automatic test_reset_mid();
    logic [WD-1:0] e;
    out_ready = 1'b1;
    send(4'h1); send(4'h2);
    RST_X    = 1'b0;
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h9;
    tick();
    RST_X    = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || frame_cnt !== 8'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_frame: got valid=%b data=%h cnt=%0d rdy=%b want 0/0/0/1", out_valid, out_data, frame_cnt, in_ready);
    end
    out_ready = 1'b0;
    send(4'h1); send(4'h2); send(4'h4); send(4'h8);
    RST_X     = 1'b0;
    out_ready = 1'b1;
    tick();
    RST_X     = 1'b1;
    out_ready = 1'b0;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || frame_cnt !== 8'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_hold: got valid=%b data=%h cnt=%0d rdy=%b want 0/0/0/1", out_valid, out_data, frame_cnt, in_ready);
    end
    send(4'h1); send(4'h2); send(4'h4); send(4'h8);
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e || e !== 4'hF) begin
      failures++; $display("FAIL rst_next_frame: got valid=%b data=%h want 1/F (model %h)", out_valid, out_data, e);
    end
    out_ready = 1'b1;
    tick();
    m_frames++;
  endtask

  task automatic test_wrap();
    logic [WD-1:0] e;
    int            bad;
    RST_X = 1'b0;
    tick();
    RST_X = 1'b1;
    model_reset();
    out_ready = 1'b1;
    bad       = 0;
    for (int f = 0; f < 256; f++) begin
      for (int w = 0; w < FL; w++) send(4'($urandom_range(0, 15)));
      e = pop_exp();
      if (out_valid !== 1'b1 || out_data !== e) bad++;
      tick();
      m_frames++;
      if (f == 254) begin
        checks++;
        if (frame_cnt !== 8'd255) begin
          failures++; $display("FAIL wrap_255: got %0d want 255", frame_cnt);
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL wrap_checksums: got %0d wrong frames want 0", bad);
    end
    checks++;
    if (frame_cnt !== m_frames || frame_cnt !== 8'd0) begin
      failures++; $display("FAIL wrap_zero: got %0d want 0", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_hold();
    test_clr();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
